nvdla_axi_stub_responder: RTL and testbench

// - AXI4 slave-side terminator for NVDLA master ports left unconnected in reduced configurations
//   (e.g. the second DBB/SRAMIF port on nv_small).
// - Completes every read burst with zero data and every write burst with a B response.
// - A stray request therefore never hangs the DMA engines.
// - Sits between the NVDLA top-level AXI master port and nothing; instantiated in the config wrapper.

---
 rtl/nvdla_axi_stub_responder.sv | 198 +++++++++++++++++++
 tb/tb_nvdla_axi_stub_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_axi_stub_responder.sv
// AXI4 slave terminator for unused NVDLA master ports: zero-data reads, OKAY write responses.
// Optional error logging (SLVERR responses, err_flag/err_addr) under NVDLA_AXI_STUB_ERRLOG_EN.
module nvdla_axi_stub_responder #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
) (
  input  logic                dla_core_clk,
  input  logic                dla_reset,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp
`ifdef NVDLA_AXI_STUB_ERRLOG_EN
  ,
  output logic                err_flag,
  output logic [ADDR_W-1:0]   err_addr
`endif
);

`ifdef NVDLA_AXI_STUB_ERRLOG_EN
  localparam logic [1:0] RESP = 2'b10;
`else
  localparam logic [1:0] RESP = 2'b00;
`endif

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

  rd_state_e       rd_state_q, rd_state_d;
  logic [7:0]      rd_cnt_q, rd_cnt_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic            arready_q, arready_d;

  wr_state_e       wr_state_q, wr_state_d;
  logic [7:0]      wr_cnt_q, wr_cnt_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic            awready_q, awready_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = arvalid && arready_q;
  assign aw_hs = awvalid && awready_q;
  assign r_hs  = rvalid && rready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

  assign arready = arready_q;
  assign awready = awready_q;
  assign rvalid  = (rd_state_q == RD_DATA);
  assign rlast   = rvalid && (rd_cnt_q == 8'd0);
  assign rid     = rid_q;
  assign rdata   = '0;
  assign rresp   = rvalid ? RESP : 2'b00;
  assign wready  = (wr_state_q == WR_DATA);
  assign bvalid  = (wr_state_q == WR_RESP);
  assign bid     = bid_q;
  assign bresp   = bvalid ? RESP : 2'b00;

  // Ready re-arms one cycle after the FSM is seen back in IDLE.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rid_d      = rid_q;
    arready_d  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rd_state_d = RD_DATA;
          rd_cnt_d   = arlen;
          rid_d      = arid;
          arready_d  = 1'b0;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          if (rd_cnt_q == 8'd0) rd_state_d = RD_IDLE;
          else                  rd_cnt_d   = rd_cnt_q - 8'd1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Burst length is enforced by count; wlast has no say in termination.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    bid_d      = bid_q;
    awready_d  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          wr_state_d = WR_DATA;
          wr_cnt_d   = awlen;
          bid_d      = awid;
          awready_d  = 1'b0;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          if (wr_cnt_q == 8'd0) wr_state_d = WR_RESP;
          else                  wr_cnt_d   = wr_cnt_q - 8'd1;
        end
      end
      WR_RESP: begin
        if (b_hs) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge dla_core_clk or posedge dla_reset) begin
    if (dla_reset) begin
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= 8'd0;
      rid_q      <= '0;
      arready_q  <= 1'b0;
      wr_state_q <= WR_IDLE;
      wr_cnt_q   <= 8'd0;
      bid_q      <= '0;
      awready_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rid_q      <= rid_d;
      arready_q  <= arready_d;
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      bid_q      <= bid_d;
      awready_q  <= awready_d;
    end
  end

`ifdef NVDLA_AXI_STUB_ERRLOG_EN
  logic              err_flag_q, err_flag_d;
  logic              err_cap_q, err_cap_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;

  // Any request reaching a stub is an error; address of the first one is kept.
  always_comb begin
    err_flag_d = err_flag_q;
    err_cap_d  = err_cap_q;
    err_addr_d = err_addr_q;
    if (ar_hs || aw_hs) err_flag_d = 1'b1;
    if (w_hs && (wlast != (wr_cnt_q == 8'd0))) err_flag_d = 1'b1;
    if (!err_cap_q && (ar_hs || aw_hs)) begin
      err_cap_d  = 1'b1;
      err_addr_d = ar_hs ? araddr : awaddr;
    end
  end

  always_ff @(posedge dla_core_clk or posedge dla_reset) begin
    if (dla_reset) begin
      err_flag_q <= 1'b0;
      err_cap_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      err_cap_q  <= err_cap_d;
      err_addr_q <= err_addr_d;
    end
  end

  logic unused_sink;
  assign unused_sink = ^{wdata, wstrb};
`else
  logic unused_sink;
  assign unused_sink = ^{araddr, awaddr, wdata, wstrb, wlast};
`endif

endmodule

// File: tb/tb_nvdla_axi_stub_responder.sv
// Scoreboard bench for nvdla_axi_stub_responder; expected R/B responses are queued by stimulus
// and popped by a negedge monitor on each handshake. ERRLOG checks follow NVDLA_AXI_STUB_ERRLOG_EN.
module tb_nvdla_axi_stub_responder;

`ifdef NVDLA_AXI_STUB_ERRLOG_EN
  localparam logic [1:0] RESP = 2'b10;
`else
  localparam logic [1:0] RESP = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [7:0]  arid, arlen, rid;
  logic [63:0] araddr, rdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [7:0]  awid, awlen, bid, wstrb;
  logic [63:0] awaddr, wdata;
`ifdef NVDLA_AXI_STUB_ERRLOG_EN
  logic        err_flag;
  logic [63:0] err_addr;
`endif

  always #5 clk = ~clk;

  nvdla_axi_stub_responder dut (
    .dla_core_clk(clk), .dla_reset(rst),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
`ifdef NVDLA_AXI_STUB_ERRLOG_EN
    , .err_flag(err_flag), .err_addr(err_addr)
`endif
  );

  typedef struct packed {logic [7:0] id; logic last;} rexp_t;
  rexp_t      rq[$];
  logic [7:0] bq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen at the negedge completes on the next rising edge.
  always @(negedge clk) begin
    rexp_t e;
    logic [7:0] eb;
    if (!rst) begin
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected_beat", {63'd0, rvalid}, 64'd0);
        else begin
          e = rq.pop_front();
          chk("rid", {56'd0, rid}, {56'd0, e.id});
          chk("rlast", {63'd0, rlast}, {63'd0, e.last});
          chk("rdata", rdata, 64'd0);
          chk("rresp", {62'd0, rresp}, {62'd0, RESP});
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected_resp", {63'd0, bvalid}, 64'd0);
        else begin
          eb = bq.pop_front();
          chk("bid", {56'd0, bid}, {56'd0, eb});
          chk("bresp", {62'd0, bresp}, {62'd0, RESP});
        end
      end
    end
  end

  task automatic wait_arready;
    int t = 0;
    while (!arready && t < 20) begin tick; t++; end
    chk("arready_wait", {63'd0, arready}, 64'd1);
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < limit) begin tick; t++; end
    chk("r_queue_drained", rq.size(), 0);
    chk("b_queue_drained", bq.size(), 0);
    rq.delete();
    bq.delete();
  endtask

  task automatic do_read(input logic [7:0] id, input logic [7:0] len);
    wait_arready;
    arvalid = 1'b1; arid = id; arlen = len; araddr = 64'h2000;
    for (int i = 0; i <= int'(len); i++) rq.push_back('{id: id, last: (i == int'(len))});
    tick;
    arvalid = 1'b0;
    chk("arready_drop", {63'd0, arready}, 64'd0);
  endtask

  task automatic do_write(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input int wl_idx, input int pre, input int bhold);
    int t;
    bready = (bhold == 0);
    wvalid = 1'b1; wdata = 64'hDEAD_BEEF; wstrb = 8'hFF; wlast = (wl_idx == 0);
    for (int i = 0; i < pre; i++) begin
      chk("wready_before_aw", {63'd0, wready}, 64'd0);
      tick;
    end
    t = 0;
    while (!awready && t < 20) begin tick; t++; end
    chk("awready_wait", {63'd0, awready}, 64'd1);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
    bq.push_back(id);
    tick;
    awvalid = 1'b0;
    chk("awready_drop", {63'd0, awready}, 64'd0);
    for (int i = 0; i <= int'(len); i++) begin
      wlast = (i == wl_idx);
      t = 0;
      while (!wready && t < 20) begin tick; t++; end
      chk("wready_beat", {63'd0, wready}, 64'd1);
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("wready_after_burst", {63'd0, wready}, 64'd0);
    for (int i = 0; i < bhold; i++) begin
      chk("bvalid_hold", {63'd0, bvalid}, 64'd1);
      chk("bid_hold", {56'd0, bid}, {56'd0, id});
      tick;
    end
    bready = 1'b1;
    drain(20);
    chk("bvalid_done", {63'd0, bvalid}, 64'd0);
  endtask

  initial begin
    int t;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; rready = 1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1;
    tick; tick;
    chk("rst_arready", {63'd0, arready}, 64'd0);
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_wready", {63'd0, wready}, 64'd0);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("rst_rlast", {63'd0, rlast}, 64'd0);
    chk("rst_ids", {48'd0, rid, bid}, 64'd0);
    chk("rst_resps", {60'd0, rresp, bresp}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst = 1'b0;
    tick;
    chk("arready_after_rst", {63'd0, arready}, 64'd1);
    chk("awready_after_rst", {63'd0, awready}, 64'd1);

    // 4-beat read, rready held high
    do_read(8'h5A, 8'd3);
    t = 0;
    while (rq.size() != 0 && t < 40) begin tick; t++; end
    chk("rd1_beats_done", rq.size(), 0);
    chk("rd1_rvalid_drop", {63'd0, rvalid}, 64'd0);
    chk("rd1_arready_dead", {63'd0, arready}, 64'd0);
    tick;
    chk("rd1_arready_back", {63'd0, arready}, 64'd1);

    // 2-beat read with rready 1,0,1
    do_read(8'h21, 8'd1);
    chk("rd2_beat0_last", {63'd0, rlast}, 64'd0);
    tick;
    rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rd2_stall_rvalid", {63'd0, rvalid}, 64'd1);
      chk("rd2_stall_rid", {56'd0, rid}, 64'h21);
      chk("rd2_stall_rlast", {63'd0, rlast}, 64'd1);
      tick;
    end
    rready = 1'b1;
    drain(20);

    // W beats ahead of AW, B held off by bready for 5 cycles
    do_write(8'h03, 64'h3000, 8'd2, 2, 3, 5);

    // Simultaneous AR and AW, single beat each
    t = 0;
    while (!(arready && awready) && t < 20) begin tick; t++; end
    chk("both_ready", {62'd0, arready, awready}, 64'd3);
    arvalid = 1'b1; arid = 8'h44; arlen = 8'd0; araddr = 64'h4000;
    awvalid = 1'b1; awid = 8'h55; awlen = 8'd0; awaddr = 64'h5000;
    wvalid = 1'b1; wlast = 1'b1;
    rq.push_back('{id: 8'h44, last: 1'b1});
    bq.push_back(8'h55);
    tick;
    arvalid = 1'b0; awvalid = 1'b0;
    chk("sim_readies_drop", {62'd0, arready, awready}, 64'd0);
    chk("sim_rvalid_wready", {62'd0, rvalid, wready}, 64'd3);
    tick;
    wvalid = 1'b0; wlast = 1'b0;
    chk("sim_r_done", rq.size(), 0);
    drain(20);

    // Reset during beat 2 of an 8-beat read
    do_read(8'h77, 8'd7);
    t = 0;
    while (rq.size() > 6 && t < 20) begin tick; t++; end
    chk("rd3_at_beat2", rq.size(), 6);
    rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_mid_arready", {63'd0, arready}, 64'd0);
    rq.delete();
    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_mid_arready_back", {63'd0, arready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_residual", {63'd0, rvalid}, 64'd0);
      tick;
    end

`ifdef NVDLA_AXI_STUB_ERRLOG_EN
    chk("err_flag_clear", {63'd0, err_flag}, 64'd0);
`endif
    // 2-beat write with wlast on beat 0: still consumes both beats
    do_write(8'h11, 64'h1000, 8'd1, 0, 0, 0);
`ifdef NVDLA_AXI_STUB_ERRLOG_EN
    chk("err_flag_set", {63'd0, err_flag}, 64'd1);
    chk("err_addr", err_addr, 64'h1000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
